// File: rtl/dmem_stage.sv
// dmem_stage: Y86-64 memory stage with a handshaked word RAM, configurable read latency and fault checks
module dmem_stage #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        icode_i,
  input  logic [ADDR_W-1:0] valA_i,
  input  logic [ADDR_W-1:0] valE_i,
  input  logic [ADDR_W-1:0] valP_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [3:0]        icode_o,
  output logic [ADDR_W-1:0] valE_o,
  output logic [DATA_W-1:0] valM_o,
  output logic              dmem_error_o,
  output logic              error_sticky_o
);
  localparam int BYTES     = DATA_W / 8;
  localparam int OFF       = $clog2(BYTES);
  localparam int IDX       = $clog2(DEPTH_WORDS);
  localparam int MEM_BYTES = DEPTH_WORDS * BYTES;
  localparam logic [3:0] IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, ICALL = 4'h8;
  localparam logic [3:0] IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state;
  logic is_w, is_r, fault, accept, rfault;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [IDX-1:0] widx, ridx;
  logic [2:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  assign is_w    = icode_i == IRMMOVQ || icode_i == ICALL || icode_i == IPUSHQ;
  assign is_r    = icode_i == IMRMOVQ || icode_i == IRET || icode_i == IPOPQ;
  assign addr    = (icode_i == IRET || icode_i == IPOPQ) ? valA_i :
                   (is_w || icode_i == IMRMOVQ) ? valE_i : '0;
  assign wdata   = DATA_W'(icode_i == ICALL ? valP_i : valA_i);
  assign widx    = addr[OFF +: IDX];
  assign fault   = (is_w || is_r) && ({1'b0, addr} >= (ADDR_W+1)'(MEM_BYTES) ||
                   (ALIGN_CHECK != 0 && (addr & ADDR_W'(BYTES - 1)) != '0));
  assign ready_o = state == IDLE || (state == HOLD && ready_i);
  assign accept  = valid_i && ready_o;
  // RAM is deliberately outside the reset domain so committed writes survive reset
  always_ff @(posedge clk_i)
    if (accept && is_w && !fault) mem[widx] <= wdata;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      valid_o        <= 1'b0;
      icode_o        <= '0;
      valE_o         <= '0;
      valM_o         <= '0;
      dmem_error_o   <= 1'b0;
      error_sticky_o <= 1'b0;
      cnt            <= '0;
      ridx           <= '0;
      rfault         <= 1'b0;
    end else if (accept) begin
      icode_o        <= icode_i;
      valE_o         <= valE_i;
      dmem_error_o   <= fault;
      error_sticky_o <= error_sticky_o | fault;
      ridx           <= widx;
      rfault         <= fault;
      valM_o         <= (is_r && !fault && READ_LAT == 1) ? mem[widx] : '0;
      if (is_r && READ_LAT > 1) begin
        state   <= WAIT;
        valid_o <= 1'b0;
        cnt     <= 3'(READ_LAT - 2);
      end else begin
        state   <= HOLD;
        valid_o <= 1'b1;
      end
    end else if (state == WAIT) begin
      if (cnt == '0) begin
        state   <= HOLD;
        valid_o <= 1'b1;
        valM_o  <= rfault ? '0 : mem[ridx];
      end else cnt <= cnt - 3'd1;
    end else if (state == HOLD && ready_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
    end
  end
endmodule
